// File: rtl/spiker_adapter_pkg.sv
// Shared types and defaults for the spiker adapter: word geometry, controller state encoding.
package spiker_adapter_pkg;

    localparam int unsigned DEF_WIDTH          = 32;
    localparam int unsigned DEF_N_SPIKES       = 784;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2
    } ctrl_state_e;

    typedef logic [DEF_WIDTH-1:0] spike_word_t;

endpackage

// File: rtl/spiker_word_mask.sv
// Zeroes the bits of one stream word whose global spike index is at or beyond N_SPIKES.
module spiker_word_mask
    import spiker_adapter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned N_SPIKES = DEF_N_SPIKES,
    parameter int unsigned IDX_W    = 5
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic [WIDTH-1:0] word_i,
    output logic [WIDTH-1:0] word_c
);

    always_comb begin
        word_c = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            word_c[b] = word_i[b] & ((32'(idx_i) * WIDTH + b) < N_SPIKES);
        end
    end

endmodule

// File: rtl/spiker_stream_ctrl.sv
// Sequencer: snapshots spike words, streams them to the core, collects the same number of
// result words back with a receive-idle timeout, and reports busy/done/error.
module spiker_stream_ctrl
    import spiker_adapter_pkg::*;
#(
    parameter int unsigned  WIDTH          = DEF_WIDTH,
    parameter int unsigned  N_SPIKES       = DEF_N_SPIKES,
    parameter int unsigned  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int unsigned N_WORDS        = ceil_div(N_SPIKES, WIDTH),
    localparam int unsigned CNT_W          = $clog2(N_WORDS + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [N_WORDS*WIDTH-1:0]   words_i,
    output logic [WIDTH-1:0]           tx_data_o,
    output logic                       tx_valid_o,
    output logic                       tx_last_o,
    input  logic                       tx_ready_i,
    input  logic [WIDTH-1:0]           rx_data_i,
    input  logic                       rx_valid_i,
    output logic                       rx_ready_o,
    output logic [N_WORDS*WIDTH-1:0]   result_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int unsigned      BUS_W    = N_WORDS * WIDTH;
    localparam int unsigned      TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic [BUS_W-1:0] snap_q, snap_d;
    logic [BUS_W-1:0] result_q, result_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;
    logic             rx_ready_q, rx_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [BUS_W-1:0] words_masked_c;
    logic [WIDTH-1:0] rx_masked_c;

    // Padding mask on the snapshot path, one instance per word slot.
    for (genvar k = 0; k < N_WORDS; k++) begin : g_snap_mask
        spiker_word_mask #(
            .WIDTH    (WIDTH),
            .N_SPIKES (N_SPIKES),
            .IDX_W    (CNT_W)
        ) u_snap_mask (
            .idx_i  (CNT_W'(k)),
            .word_i (words_i[k*WIDTH +: WIDTH]),
            .word_c (words_masked_c[k*WIDTH +: WIDTH])
        );
    end

    spiker_word_mask #(
        .WIDTH    (WIDTH),
        .N_SPIKES (N_SPIKES),
        .IDX_W    (CNT_W)
    ) u_rx_mask (
        .idx_i  (cnt_q),
        .word_i (rx_data_i),
        .word_c (rx_masked_c)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            snap_q     <= '0;
            result_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            snap_q     <= snap_d;
            result_q   <= result_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next state; abort takes priority over any beat or timeout in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        snap_d     = snap_q;
        result_d   = result_q;
        done_d     = done_q;
        err_d      = err_q;
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        rx_ready_d = 1'b0;
        busy_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    snap_d   = words_masked_c;
                    result_d = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    tcnt_d   = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (tx_valid_q && tx_ready_i) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        tcnt_d  = '0;
                        state_d = ST_RECV;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RECV: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (rx_valid_i) begin
                    result_d[32'(cnt_q)*WIDTH +: WIDTH] = rx_masked_c;
                    tcnt_d = '0;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tcnt_q == TO_MAX) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stream outputs are registered images of the upcoming state and word index.
        tx_valid_d = (state_d == ST_SEND);
        tx_last_d  = (state_d == ST_SEND) && (cnt_d == LAST_IDX);
        rx_ready_d = (state_d == ST_RECV);
        busy_d     = (state_d != ST_IDLE);
        if (state_d == ST_SEND) begin
            tx_data_d = snap_d[32'(cnt_d)*WIDTH +: WIDTH];
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_last_o  = tx_last_q;
    assign rx_ready_o = rx_ready_q;
    assign result_o   = result_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_spiker_stream_ctrl.sv
// Randomized bench for spiker_stream_ctrl with a transaction-level reference model.
module tb_spiker_stream_ctrl;
    import spiker_adapter_pkg::*;

    localparam int WIDTH    = 32;
    localparam int N_SPIKES = 784;
    localparam int TIMEOUT  = 16;
    localparam int N_WORDS  = (N_SPIKES + WIDTH - 1) / WIDTH;
    localparam int BUS_W    = N_WORDS * WIDTH;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [BUS_W-1:0] words_i = '0;
    logic [WIDTH-1:0] tx_data_o;
    logic             tx_valid_o;
    logic             tx_last_o;
    logic             tx_ready_i = 1'b0;
    logic [WIDTH-1:0] rx_data_i = '0;
    logic             rx_valid_i = 1'b0;
    logic             rx_ready_o;
    logic [BUS_W-1:0] result_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    spiker_stream_ctrl #(
        .WIDTH          (WIDTH),
        .N_SPIKES       (N_SPIKES),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .words_i    (words_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_last_o  (tx_last_o),
        .tx_ready_i (tx_ready_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .result_o   (result_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    spike_word_t res_exp [N_WORDS];
    logic        done_exp = 1'b0;
    logic        err_exp  = 1'b0;

    // Per-transaction scenario knobs; -1 disables an option.
    int cfg_ready_mode, cfg_rx_gap, cfg_abort_tx, cfg_stop_rx, cfg_restart_tx;
    int cfg_rst_rx, cfg_abort_last, cfg_loop, cfg_exp_busy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic spike_word_t word_mask(input int k);
        int valid;
        valid = N_SPIKES - k * WIDTH;
        if (valid >= WIDTH) return '1;
        if (valid <= 0) return '0;
        return (spike_word_t'(1) << valid) - spike_word_t'(1);
    endfunction

    task automatic cfg_defaults();
        cfg_ready_mode = 0; cfg_rx_gap = -1; cfg_abort_tx = -1; cfg_stop_rx = -1;
        cfg_restart_tx = -1; cfg_rst_rx = -1; cfg_abort_last = 0; cfg_loop = 0;
        cfg_exp_busy = -1;
    endtask

    function automatic int next_gap();
        return (cfg_rx_gap < 0) ? int'($urandom_range(0, 3)) : cfg_rx_gap;
    endfunction

    task automatic check_final(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            seen = seen | tx_valid_o | rx_ready_o | busy_o;
            rx_valid_i = 1'b1;
            rx_data_i  = $urandom();
            tx_ready_i = 1'($urandom_range(0, 1));
        end
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b0;
        check_eq({tag, "_idle_quiet"}, 64'(seen), 64'(0));
        check_eq({tag, "_done"}, 64'(done_o), 64'(done_exp));
        check_eq({tag, "_err"}, 64'(err_o), 64'(err_exp));
        for (int k = 0; k < N_WORDS; k++)
            check_eq($sformatf("%s_result_w%0d", tag, k), 64'(result_o[k*WIDTH +: WIDTH]),
                     64'(res_exp[k]));
    endtask

    task automatic run_txn(input string tag);
        spike_word_t exp_tx [N_WORDS];
        int  tx_idx = 0, rx_idx = 0, gap = 0, cur_gap, busy_cyc = 0;
        int  iter = 0, last_beat = 0, abort_iter = -1;
        bit  fin = 1'b0, did_rst = 1'b0;
        for (int k = 0; k < N_WORDS; k++) begin
            exp_tx[k]  = words_i[k*WIDTH +: WIDTH] & word_mask(k);
            res_exp[k] = '0;
        end
        done_exp = 1'b0;
        err_exp  = (cfg_stop_rx >= 0);
        cur_gap  = next_gap();
        start_i  = 1'b1;
        while (!fin) begin
            @(posedge clk_i); #1;
            iter++;
            start_i = 1'b0; abort_i = 1'b0; tx_ready_i = 1'b0; rx_valid_i = 1'b0;
            rx_data_i = $urandom();
            if (busy_o) busy_cyc++;
            if (iter == 1) check_eq({tag, "_tx_latency"}, 64'(tx_valid_o), 64'(1));
            if (!busy_o || iter > 3000) begin
                check_eq({tag, "_txn_bound"}, 64'(busy_o), 64'(0));
                fin = 1'b1;
            end else begin
                if (tx_valid_o) begin
                    check_eq($sformatf("%s_tx_data_b%0d", tag, tx_idx), 64'(tx_data_o),
                             64'(exp_tx[tx_idx % N_WORDS]));
                    check_eq($sformatf("%s_tx_last_b%0d", tag, tx_idx), 64'(tx_last_o),
                             64'(tx_idx == N_WORDS - 1));
                    case (cfg_ready_mode)
                        0:       tx_ready_i = 1'b1;
                        1:       tx_ready_i = 1'(iter % 2);
                        default: tx_ready_i = 1'($urandom_range(0, 1));
                    endcase
                    if (cfg_restart_tx >= 0 && tx_idx == cfg_restart_tx) start_i = 1'b1;
                    if (cfg_abort_tx >= 0 && tx_idx == cfg_abort_tx) begin
                        abort_i = 1'b1;
                        abort_iter = iter;
                    end else if (tx_ready_i) begin
                        tx_idx++;
                    end
                end
                if (rx_ready_o) begin
                    if (cfg_rst_rx >= 0 && rx_idx == cfg_rst_rx) begin
                        rst_ni = 1'b0;
                        #1;
                        check_eq({tag, "_rst_busy"}, 64'(busy_o), 64'(0));
                        check_eq({tag, "_rst_rx_ready"}, 64'(rx_ready_o), 64'(0));
                        check_eq({tag, "_rst_tx_valid"}, 64'(tx_valid_o), 64'(0));
                        check_eq({tag, "_rst_flags"}, 64'({done_o, err_o}), 64'(0));
                        check_eq({tag, "_rst_result"}, 64'(|result_o), 64'(0));
                        for (int k = 0; k < N_WORDS; k++) res_exp[k] = '0;
                        err_exp = 1'b0;
                        did_rst = 1'b1;
                        #2 rst_ni = 1'b1;
                        fin = 1'b1;
                    end else if (cfg_stop_rx >= 0 && rx_idx >= cfg_stop_rx) begin
                        rx_valid_i = 1'b0;
                    end else if (gap >= cur_gap) begin
                        rx_valid_i = 1'b1;
                        if (cfg_loop != 0) rx_data_i = exp_tx[rx_idx];
                        if (cfg_abort_last != 0 && rx_idx == N_WORDS - 1) begin
                            abort_i = 1'b1;
                            abort_iter = iter;
                        end else begin
                            res_exp[rx_idx] = rx_data_i & word_mask(rx_idx);
                            rx_idx++;
                            last_beat = iter;
                            if (rx_idx == N_WORDS) done_exp = 1'b1;
                        end
                        gap = 0;
                        cur_gap = next_gap();
                    end else begin
                        gap++;
                    end
                end else begin
                    rx_valid_i = 1'($urandom_range(0, 1));
                end
            end
        end
        if (cfg_exp_busy >= 0) check_eq({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(cfg_exp_busy));
        if (abort_iter >= 0) check_eq({tag, "_abort_latency"}, 64'(iter), 64'(abort_iter + 1));
        if (cfg_stop_rx >= 0)
            check_eq({tag, "_timeout_latency"}, 64'(iter - last_beat - 1), 64'(TIMEOUT));
        if (!did_rst)
            check_eq({tag, "_tx_beats"}, 64'(tx_idx),
                     64'((cfg_abort_tx >= 0) ? cfg_abort_tx : N_WORDS));
        check_final(tag);
    endtask

    task automatic rand_words();
        for (int k = 0; k < N_WORDS; k++) words_i[k*WIDTH +: WIDTH] = $urandom();
    endtask

    initial begin
        cfg_defaults();
        for (int k = 0; k < N_WORDS; k++) res_exp[k] = '0;
        #3;
        check_eq("por_busy", 64'(busy_o), 64'(0));
        check_eq("por_stream", 64'({tx_valid_o, tx_last_o, rx_ready_o}), 64'(0));
        check_eq("por_flags", 64'({done_o, err_o}), 64'(0));
        check_eq("por_result", 64'(|result_o), 64'(0));
        #9 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // All-ones words, always ready, rx echoes tx two idle cycles later.
        cfg_defaults(); cfg_rx_gap = 2; cfg_loop = 1; cfg_exp_busy = N_WORDS + 3 * N_WORDS;
        words_i = '1;
        run_txn("t1");
        check_eq("t1_word24_padded", 64'(result_o[24*WIDTH +: WIDTH]), 64'(32'h0000_FFFF));

        // Incrementing words with a toggling ready.
        cfg_defaults(); cfg_ready_mode = 1;
        for (int k = 0; k < N_WORDS; k++) words_i[k*WIDTH +: WIDTH] = WIDTH'(k);
        run_txn("t2");

        // Start and abort together in IDLE: abort wins, done flag untouched.
        start_i = 1'b1; abort_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; abort_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq("t5_idle_abort_busy", 64'(busy_o), 64'(0));
        check_eq("t5_idle_abort_tx", 64'(tx_valid_o), 64'(0));
        check_eq("t5_idle_abort_done", 64'(done_o), 64'(done_exp));

        cfg_defaults(); cfg_stop_rx = 3; rand_words();
        run_txn("t3");

        cfg_defaults(); cfg_abort_tx = 10; cfg_ready_mode = 2; rand_words();
        run_txn("t4");
        cfg_defaults(); rand_words();
        run_txn("t4b");

        cfg_defaults(); cfg_restart_tx = 5; cfg_ready_mode = 2; rand_words();
        run_txn("t5");

        cfg_defaults(); cfg_abort_last = 1; rand_words();
        run_txn("tal");

        cfg_defaults(); cfg_rst_rx = 5; cfg_ready_mode = 2; rand_words();
        run_txn("t6");
        cfg_defaults(); rand_words();
        run_txn("t6b");

        for (int r = 0; r < 3; r++) begin
            cfg_defaults(); cfg_ready_mode = 2; rand_words();
            run_txn($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
